// File: rtl/gate_tt_checker.sv
// Sweeps every input vector into a combinational gate under test and checks
// the sampled output against a truth-table parameter.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// DRIVE  | present vec on dut_in, clear settle counter
// SETTLE | hold dut_in, sample dut_y on the last settle cycle
// DONE   | one-cycle completion pulse
module gate_tt_checker #(
    parameter int N_IN = 2,
    parameter int SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0] TT = 4'b1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_y,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    localparam int EW = N_IN + 1;
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [EW-1:0]   err_q, err_d;
    logic            fail_valid_q, fail_valid_d;
    logic            pass_q, pass_d;
    logic            sample, last_vec, mismatch;

    assign sample   = (state_q == S_SETTLE) && (cnt_q == CNT_LAST);
    assign last_vec = (vec_q == VEC_LAST);
    // Case inequality so an unknown gate output counts as a mismatch.
    assign mismatch = (dut_y !== TT[vec_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            dut_in_q     <= '0;
            first_fail_q <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            dut_in_q     <= dut_in_d;
            first_fail_q <= first_fail_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            pass_q       <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DRIVE;
            S_DRIVE:  state_d = S_SETTLE;
            S_SETTLE: if (sample) state_d = last_vec ? S_DONE : S_DRIVE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vec_d        = vec_q;
        dut_in_d     = dut_in_q;
        first_fail_d = first_fail_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        pass_d       = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                end
            end
            S_DRIVE: begin
                dut_in_d = vec_q;
                cnt_d    = '0;
            end
            S_SETTLE: begin
                cnt_d = cnt_q + CW'(1);
                if (sample) begin
                    if (mismatch) begin
                        err_d = err_q + EW'(1);
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            first_fail_d = vec_q;
                        end
                    end
                    // pass is settled on entry to DONE so it is valid alongside the done pulse.
                    if (last_vec) pass_d = (err_d == '0);
                    else          vec_d  = vec_q + N_IN'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_DRIVE, S_SETTLE: busy = 1'b1;
            S_DONE:            done = 1'b1;
            default: ;
        endcase
    end

    assign dut_in     = dut_in_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: model gates driven by the checker, results
// compared against hand-derived expectations through a scoreboard queue.
module tb_gate_tt_checker;

    typedef struct {
        int mode;
        int err;
        int ff;
        int fv;
        int pass;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a = 1'b1, start_a = 1'b0, y_a;
    logic [1:0] in_a, ff_a;
    logic [2:0] err_a;
    logic       busy_a, done_a, pass_a, fv_a;

    logic       rst_b = 1'b1, start_b = 1'b0, y_b;
    logic [1:0] in_b, ff_b;
    logic [2:0] err_b;
    logic       busy_b, done_b, pass_b, fv_b;

    int mode = 0;
    logic [1:0] d1_a = '0, d2_a = '0, d1_b = '0, d2_b = '0;
    always @(posedge clk) begin
        d1_a <= in_a; d2_a <= d1_a;
        d1_b <= in_b; d2_b <= d1_b;
    end

    always_comb begin
        case (mode)
            0: y_a = &in_a;
            1: y_a = 1'b0;
            2: y_a = |in_a;
            3: y_a = ~&in_a;
            4: y_a = ^in_a;
            default: y_a = &d2_a;
        endcase
    end
    assign y_b = &d2_b;

    gate_tt_checker #(.N_IN(2), .SETTLE(1), .TT(4'b1000)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .dut_y(y_a), .dut_in(in_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fv_a), .first_fail(ff_a));

    gate_tt_checker #(.N_IN(2), .SETTLE(3), .TT(4'b1000)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .dut_y(y_b), .dut_in(in_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fv_b), .first_fail(ff_b));

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];
    exp_t tbl[5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_a();
        @(negedge clk); rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
    endtask

    // Runs one sweep on instance A; poke>0 pulses start again at that cycle.
    task automatic sweep_a(input exp_t e, input int poke);
        exp_t got;
        int k;
        mode = e.mode;
        sb_q.push_back(e);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("busy_after_accept", busy_a, 1);
        k = 0;
        while (k < 100) begin
            @(negedge clk); k++;
            if (poke > 0 && k == poke)     start_a = 1'b1;
            if (poke > 0 && k == poke + 1) start_a = 1'b0;
            if (done_a) break;
            chk("busy_in_sweep", busy_a, 1);
            chk("dut_in_step", int'(in_a), (k - 1) / 2);
        end
        if (k >= 100) chk("done_timeout", 0, 1);
        got = sb_q.pop_front();
        chk("done_latency", k, got.lat);
        chk("busy_at_done", busy_a, 0);
        chk("dut_in_last", int'(in_a), 3);
        chk("err_count", int'(err_a), got.err);
        chk("fail_valid", int'(fv_a), got.fv);
        if (got.fv != 0) chk("first_fail", int'(ff_a), got.ff);
        chk("pass", int'(pass_a), got.pass);
        @(negedge clk);
        chk("done_one_cycle", done_a, 0);
    endtask

    initial begin
        int k, t0, seen_done;
        tbl[0] = '{mode: 0, err: 0, ff: 0, fv: 0, pass: 1, lat: 8};
        tbl[1] = '{mode: 1, err: 1, ff: 3, fv: 1, pass: 0, lat: 8};
        tbl[2] = '{mode: 2, err: 2, ff: 1, fv: 1, pass: 0, lat: 8};
        tbl[3] = '{mode: 3, err: 4, ff: 0, fv: 1, pass: 0, lat: 8};
        tbl[4] = '{mode: 4, err: 3, ff: 1, fv: 1, pass: 0, lat: 8};

        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_fv", fv_a, 0);
        chk("rst_ff", int'(ff_a), 0);
        chk("rst_dut_in", int'(in_a), 0);

        for (int i = 0; i < 5; i++) begin
            sweep_a(tbl[i], 0);
            if (tbl[i].mode == 2) begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (c % 5 == 4) begin
                        chk("hold_err", int'(err_a), 2);
                        chk("hold_ff", int'(ff_a), 1);
                        chk("hold_idle", busy_a, 0);
                    end
                end
            end
        end

        // Registered two-cycle gate, SETTLE=1: only vec 3 sees stale data.
        reset_a();
        sweep_a('{mode: 5, err: 1, ff: 3, fv: 1, pass: 0, lat: 8}, 0);

        // Same gate, SETTLE=3.
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        k = 0;
        while (!done_b && k < 200) begin
            @(negedge clk); k++;
        end
        chk("b_latency", k, 16);
        chk("b_pass", pass_b, 1);
        chk("b_err", int'(err_b), 0);

        // Reset mid-sweep.
        reset_a();
        mode = 2;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        k = 0;
        while (in_a != 2'd2 && k < 50) begin
            @(negedge clk); k++;
        end
        if (k >= 50) chk("wait_vec2_timeout", 0, 1);
        chk("err_before_rst", int'(err_a), 1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_dut_in", int'(in_a), 0);
        chk("midrst_err", int'(err_a), 0);
        chk("midrst_fv", fv_a, 0);
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_a) seen_done++;
            @(negedge clk);
        end
        chk("midrst_no_done", seen_done, 0);
        sweep_a('{mode: 0, err: 0, ff: 0, fv: 0, pass: 1, lat: 8}, 0);

        // start during busy is ignored.
        sweep_a('{mode: 2, err: 2, ff: 1, fv: 1, pass: 0, lat: 8}, 3);

        // start held high: back-to-back sweeps.
        mode = 2;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk);
        t0 = cyc;
        k = 0;
        while (!done_a && k < 100) begin
            @(negedge clk); k++;
        end
        chk("held_lat1", cyc - t0, 8);
        chk("held_err1", int'(err_a), 2);
        mode = 0;
        @(negedge clk);
        chk("held_idle_busy", busy_a, 0);
        @(negedge clk);
        start_a = 1'b0;
        t0 = cyc;
        chk("held_restart_busy", busy_a, 1);
        chk("held_cleared_err", int'(err_a), 0);
        chk("held_cleared_fv", fv_a, 0);
        chk("held_cleared_pass", pass_a, 0);
        k = 0;
        while (!done_a && k < 100) begin
            @(negedge clk); k++;
        end
        chk("held_lat2", cyc - t0, 8);
        chk("held_pass2", pass_a, 1);
        chk("held_err2", int'(err_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
